seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan.sv | 160 ++++++++++++++++
 tb/tb_seg7_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed 7-segment driver.
// It latches four BCD digits and scans them units -> tens -> hundreds -> thousands.
// Each digit stays lit for REFRESH_COUNT cycles.
// Leading zeros can optionally be blanked.
// Segment and anode outputs are registered, so they show the scan position and
// digit values of the previous cycle.
//
// state        | meaning
// S_UNITS      | units digit (d1) selected, an[0] low
// S_TENS       | tens digit (d2) selected, an[1] low
// S_HUNDREDS   | hundreds digit (d3) selected, an[2] low
// S_THOUSANDS  | thousands digit (d4) selected, an[3] low
module seg7_scan #(
  parameter int REFRESH_COUNT = 50000,
  parameter int BLANK_ZEROS   = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       escrever,
  input  logic [3:0] setseg1,
  input  logic [3:0] setseg2,
  input  logic [3:0] setseg3,
  input  logic [3:0] setseg4,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int            CW       = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_COUNT - 1);
  localparam logic [6:0]    SEG_OFF  = 7'b1111111;

  typedef enum logic [1:0] {
    S_UNITS     = 2'd0,
    S_TENS      = 2'd1,
    S_HUNDREDS  = 2'd2,
    S_THOUSANDS = 2'd3
  } scan_t;

  logic [CW-1:0] r_cnt;
  scan_t         r_idx;
  logic [3:0]    r_d1;
  logic [3:0]    r_d2;
  logic [3:0]    r_d3;
  logic [3:0]    r_d4;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [3:0]    w_digit;
  logic          w_blank;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;
  logic          w_wrap;

  // Active-low segment pattern {g,f,e,d,c,b,a}; codes above 9 go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // The scan position always advances by one slot and wraps from thousands to units.
  function automatic scan_t scan_next(input scan_t cur);
    scan_t n;
    case (cur)
      S_UNITS:     n = S_TENS;
      S_TENS:      n = S_HUNDREDS;
      S_HUNDREDS:  n = S_THOUSANDS;
      default:     n = S_UNITS;
    endcase
    return n;
  endfunction

  assign w_wrap = (r_cnt == CNT_LAST);

  // Pick the latched digit for the slot currently selected.
  always_comb begin
    w_digit = r_d1;
    case (r_idx)
      S_UNITS:     w_digit = r_d1;
      S_TENS:      w_digit = r_d2;
      S_HUNDREDS:  w_digit = r_d3;
      S_THOUSANDS: w_digit = r_d4;
      default:     w_digit = r_d1;
    endcase
  end

  // Leading-zero blanking: a digit goes dark when it and every higher digit are zero.
  // The units digit always stays lit, so a value of zero still shows "0".
  always_comb begin
    w_blank = 1'b0;
    if (BLANK_ZEROS != 0) begin
      case (r_idx)
        S_TENS:      w_blank = (r_d4 == 4'd0) && (r_d3 == 4'd0) && (r_d2 == 4'd0);
        S_HUNDREDS:  w_blank = (r_d4 == 4'd0) && (r_d3 == 4'd0);
        S_THOUSANDS: w_blank = (r_d4 == 4'd0);
        default:     w_blank = 1'b0;
      endcase
    end
  end

  // A blanked digit keeps its anode enabled, so every slot has the same scan timing.
  // Only the segment pattern is forced dark.
  always_comb begin
    w_seg_next = w_blank ? SEG_OFF : seg_decode(w_digit);
    w_an_next  = 4'b1111;
    case (r_idx)
      S_UNITS:     w_an_next = 4'b1110;
      S_TENS:      w_an_next = 4'b1101;
      S_HUNDREDS:  w_an_next = 4'b1011;
      S_THOUSANDS: w_an_next = 4'b0111;
      default:     w_an_next = 4'b1111;
    endcase
  end

  // Scan state, refresh counter, digit latches and registered outputs.
  // The outputs sample r_idx and r_d* before this edge updates them, which gives one cycle of latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= S_UNITS;
      r_d1  <= 4'd0;
      r_d2  <= 4'd0;
      r_d3  <= 4'd0;
      r_d4  <= 4'd0;
      r_seg <= SEG_OFF;
      r_an  <= 4'b1111;
    end else begin
      if (escrever) begin
        r_d1 <= setseg1;
        r_d2 <= setseg2;
        r_d3 <= setseg3;
        r_d4 <= setseg4;
      end
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= scan_next(r_idx);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_scan.sv
// Testbench for seg7_scan.
// Two instances share one set of inputs: one with blanking enabled and one with blanking disabled.
// A slot-level reference model predicts both instances every cycle.
module tb_seg7_scan;

  localparam int RC = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       escrever;
  logic [3:0] setseg1, setseg2, setseg3, setseg4;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan #(.REFRESH_COUNT(RC), .BLANK_ZEROS(1)) dut0 (
    .clock(clock), .reset(reset), .escrever(escrever),
    .setseg1(setseg1), .setseg2(setseg2), .setseg3(setseg3), .setseg4(setseg4),
    .seg(seg0), .an(an0)
  );

  seg7_scan #(.REFRESH_COUNT(RC), .BLANK_ZEROS(0)) dut1 (
    .clock(clock), .reset(reset), .escrever(escrever),
    .setseg1(setseg1), .setseg2(setseg2), .setseg3(setseg3), .setseg4(setseg4),
    .seg(seg1), .an(an1)
  );

  always #5 clock = ~clock;

  logic [6:0] SEG_TAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: the digit values, plus the number of run edges since the last reset.
  int  m_d [4];
  int  m_k;
  bit  m_valid = 1'b0;

  function automatic logic [6:0] model_seg(input int slot, input int bz);
    bit lead = 1'b1;
    for (int j = slot; j < 4; j++)
      if (m_d[j] != 0) lead = 1'b0;
    if (bz != 0 && slot > 0 && lead) return 7'b1111111;
    if (m_d[slot] > 9) return 7'b1111111;
    return SEG_TAB[m_d[slot]];
  endfunction

  // Each cycle, predict the outputs from the model state before this edge.
  // Then apply this edge's reset and load to the model, and compare both instances.
  initial begin
    logic [3:0] e_an;
    logic [6:0] e_s0, e_s1;
    int slot;
    forever begin
      @(posedge clock);
      if (reset) begin
        e_an = 4'b1111; e_s0 = 7'b1111111; e_s1 = 7'b1111111;
        m_k = 0;
        for (int j = 0; j < 4; j++) m_d[j] = 0;
        m_valid = 1'b1;
      end else begin
        slot = (m_k / RC) % 4;
        for (int j = 0; j < 4; j++) e_an[j] = (j != slot);
        e_s0 = model_seg(slot, 1);
        e_s1 = model_seg(slot, 0);
        m_k++;
        if (escrever) begin
          m_d[0] = int'(setseg1); m_d[1] = int'(setseg2);
          m_d[2] = int'(setseg3); m_d[3] = int'(setseg4);
        end
      end
      #1;
      if (m_valid) begin
        chk("model_an0",  {3'b000, an0}, {3'b000, e_an});
        chk("model_seg0", seg0, e_s0);
        chk("model_an1",  {3'b000, an1}, {3'b000, e_an});
        chk("model_seg1", seg1, e_s1);
      end
    end
  end

  task automatic load(input logic [3:0] a4, input logic [3:0] a3,
                      input logic [3:0] a2, input logic [3:0] a1);
    @(negedge clock);
    escrever = 1'b1; setseg4 = a4; setseg3 = a3; setseg2 = a2; setseg1 = a1;
    @(negedge clock);
    escrever = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_an(input logic [3:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (an0 === a) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_an: an never reached %b (last %b)", a, an0);
    end
  endtask

  task automatic slot_chk(input string nm, input logic [3:0] a,
                          input logic [6:0] s0, input logic [6:0] s1);
    bit ok;
    wait_an(a, ok);
    if (ok) begin
      chk({nm, "_seg0"}, seg0, s0);
      chk({nm, "_seg1"}, seg1, s1);
    end
  endtask

  function automatic logic [3:0] rnd_dig();
    if ($urandom_range(0, 1) == 0) return 4'd0;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    bit ok;
    reset = 1'b1; escrever = 1'b1;
    setseg1 = 4'd9; setseg2 = 4'd8; setseg3 = 4'd7; setseg4 = 4'd6;
    repeat (3) @(negedge clock);
    reset = 1'b0; escrever = 1'b0;

    // First display after reset: units digit shows 0.
    @(posedge clock); #1;
    chk("first_an",   {3'b000, an0}, 7'b0001110);
    chk("first_seg0", seg0, 7'b1000000);
    chk("first_seg1", seg1, 7'b1000000);
    repeat (RC) @(posedge clock); #1;
    chk("tens_an",   {3'b000, an0}, 7'b0001101);
    chk("tens_seg0", seg0, 7'b1111111);
    chk("tens_seg1", seg1, 7'b1000000);

    // Full value 1234.
    load(4'd1, 4'd2, 4'd3, 4'd4);
    slot_chk("full_u", 4'b1110, 7'b0011001, 7'b0011001);
    slot_chk("full_t", 4'b1101, 7'b0110000, 7'b0110000);
    slot_chk("full_h", 4'b1011, 7'b0100100, 7'b0100100);
    slot_chk("full_k", 4'b0111, 7'b1111001, 7'b1111001);

    // Leading zeros: 0070.
    load(4'd0, 4'd0, 4'd7, 4'd0);
    slot_chk("lz_k", 4'b0111, 7'b1111111, 7'b1000000);
    slot_chk("lz_u", 4'b1110, 7'b1000000, 7'b1000000);
    slot_chk("lz_t", 4'b1101, 7'b1111000, 7'b1111000);
    slot_chk("lz_h", 4'b1011, 7'b1111111, 7'b1000000);

    // Invalid tens code: 95C3.
    load(4'd9, 4'd5, 4'hC, 4'd3);
    slot_chk("inv_t", 4'b1101, 7'b1111111, 7'b1111111);
    slot_chk("inv_h", 4'b1011, 7'b0010010, 7'b0010010);
    slot_chk("inv_k", 4'b0111, 7'b0010000, 7'b0010000);
    slot_chk("inv_u", 4'b1110, 7'b0110000, 7'b0110000);

    // Mid-scan reset during the hundreds slot, with a simultaneous load.
    wait_an(4'b1011, ok);
    reset = 1'b1; escrever = 1'b1;
    setseg1 = 4'd5; setseg2 = 4'd6; setseg3 = 4'd7; setseg4 = 4'd8;
    @(negedge clock);
    reset = 1'b0; escrever = 1'b0;
    @(posedge clock); #1;
    chk("msr_an",   {3'b000, an0}, 7'b0001110);
    chk("msr_seg0", seg0, 7'b1000000);

    // Held strobe: the digit latches track the inputs every cycle.
    @(negedge clock);
    escrever = 1'b1;
    for (int i = 0; i < 24; i++) begin
      setseg1 = rnd_dig(); setseg2 = rnd_dig(); setseg3 = rnd_dig(); setseg4 = rnd_dig();
      @(negedge clock);
    end
    escrever = 1'b0;

    // Random traffic: sparse loads, occasional resets, zero-heavy digits.
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      escrever = ($urandom_range(0, 5) == 0);
      setseg1 = rnd_dig(); setseg2 = rnd_dig(); setseg3 = rnd_dig(); setseg4 = rnd_dig();
      @(negedge clock);
    end
    reset = 1'b0; escrever = 1'b0;
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
